// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-add multiplier; one partial-product bit per cycle.
// Returns the low or high word of the 2*WIDTH-bit product, selected at start.
module seq_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic             op,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  logic [2*WIDTH:0]   acc, acc_nxt;
  logic [WIDTH-1:0]   mcand;
  logic               neg, op_q;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] prod, prod_nxt;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     upper_sum;

  always_comb begin
    a_abs     = (sign && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
    b_abs     = (sign && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
    // Upper half is WIDTH+1 bits so the add carry lands in the top bit.
    upper_sum = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, mcand} : '0);
    acc_nxt   = {1'b0, upper_sum, acc[WIDTH-1:1]};
    prod_nxt  = neg ? -acc_nxt[2*WIDTH-1:0] : acc_nxt[2*WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc   <= '0;
      mcand <= '0;
      neg   <= 1'b0;
      op_q  <= 1'b1;
      cnt   <= '0;
      prod  <= '0;
    end else if (start) begin
      // Start always wins, so a busy restart silently drops the old job.
      acc   <= {1'b0, {WIDTH{1'b0}}, b_abs};
      mcand <= a_abs;
      neg   <= sign & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
      op_q  <= op;
      cnt   <= CNT_INIT;
    end else if (cnt != '0) begin
      acc <= acc_nxt;
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) prod <= prod_nxt;
    end
  end

  assign busy   = (cnt != '0);
  assign done   = ~busy;
  assign result = op_q ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed-vector bench for seq_multiplier: latency, word select, signs,
// restart, input isolation while busy and asynchronous reset.
module tb_seq_multiplier;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             sign = 1'b0;
  logic             op = 1'b1;
  logic [WIDTH-1:0] multiplicand = '0;
  logic [WIDTH-1:0] multiplier = '0;
  logic [WIDTH-1:0] result;
  logic             busy, done;

  int total = 0;
  int bad   = 0;
  int cycles;
  bit seen81;

  seq_multiplier #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .sign(sign), .op(op),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .result(result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic kick(input logic s, input logic o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    start = 1'b1; sign = s; op = o; multiplicand = a; multiplier = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits out busy with a bound; cycles counts edges after the start edge.
  task automatic wait_done();
    cycles = 0;
    while (busy && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
      if (result == 32'd81) seen81 = 1'b1;
    end
  endtask

  task automatic run(input string tag, input logic s, input logic o,
                     input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                     input logic [WIDTH-1:0] exp);
    kick(s, o, a, b);
    wait_done();
    chk({tag, "_lat"}, 64'(cycles), 64'd32);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_res"}, 64'(result), 64'(exp));
  endtask

  initial begin
    seen81 = 1'b0;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd1);
    chk("rst_res", 64'(result), 64'd0);
    @(negedge clk); rst = 1'b1;

    run("u7x6_lo",   1'b0, 1'b1, 32'd7, 32'd6, 32'h0000002A);
    run("u7x6_hi",   1'b0, 1'b0, 32'd7, 32'd6, 32'h00000000);
    run("s_m3x5_lo", 1'b1, 1'b1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1);
    run("s_m3x5_hi", 1'b1, 1'b0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF);
    run("umax_hi",   1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run("umax_lo",   1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    run("sm1_hi",    1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    run("sm1_lo",    1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    run("smin2_hi",  1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000);
    run("smin2_lo",  1'b1, 1'b1, 32'h80000000, 32'h80000000, 32'h00000000);
    run("sminx1_hi", 1'b1, 1'b0, 32'h80000000, 32'd1, 32'hFFFFFFFF);
    run("sminx1_lo", 1'b1, 1'b1, 32'h80000000, 32'd1, 32'h80000000);
    run("szero_hi",  1'b1, 1'b0, 32'd0, 32'hFFFFFFFB, 32'h00000000);
    run("szero_lo",  1'b1, 1'b1, 32'd0, 32'hFFFFFFFB, 32'h00000000);

    // Restart: 9*9 aborted at cycle 10 by 3*4; 81 must never show.
    seen81 = 1'b0;
    kick(1'b0, 1'b1, 32'd9, 32'd9);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (result == 32'd81) seen81 = 1'b1;
    end
    run("restart", 1'b0, 1'b1, 32'd3, 32'd4, 32'h0000000C);
    repeat (3) begin
      @(posedge clk); #1;
      if (result == 32'd81) seen81 = 1'b1;
    end
    chk("no81", 64'(seen81), 64'd0);

    // Inputs scrambled while busy must not disturb the latched job.
    kick(1'b0, 1'b1, 32'd100, 32'd200);
    cycles = 0;
    while (busy && cycles < 100) begin
      @(negedge clk);
      op = $urandom_range(0, 1); sign = $urandom_range(0, 1);
      multiplicand = $urandom; multiplier = $urandom;
      @(posedge clk); #1;
      cycles++;
    end
    chk("toggle_lat", 64'(cycles), 64'd32);
    chk("toggle_res", 64'(result), 64'h00004E20);

    // Asynchronous reset in the middle of an operation.
    kick(1'b0, 1'b1, 32'd5, 32'd5);
    repeat (14) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd1);
    chk("mid_rst_res", 64'(result), 64'd0);
    @(negedge clk); rst = 1'b1;
    run("post_rst", 1'b0, 1'b1, 32'd2, 32'd3, 32'h00000006);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Iterative radix-2 shift-add integer multiplier. It is the companion arithmetic unit to the sequential divider in the integer execute stage.
- Same start/done handshake and sign/op select style as the divider, so the execute-stage controller drives both units identically.
- Produces a 2*WIDTH-bit product internally. Returns either the low or the high word, covering RISC-V MUL and MULH/MULHU.

Parameters:
WIDTH, 32, operand and result width in bits (must be >= 2).
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous reset, active-low (asserted when 0).
start  input  1  one-cycle pulse; latches operands and begins a multiply.
sign  input  1  1 = both operands two's-complement signed; 0 = both unsigned.
op  input  1  1 = return low word of product; 0 = return high word.
multiplicand  input  WIDTH  operand A, sampled only on start.
multiplier  input  WIDTH  operand B, sampled only on start.
result  output  WIDTH  selected product word, held stable while done=1.
busy  output  1  high while iterations are in progress.
done  output  1  equals !busy; high when idle and result is valid.

Behaviour:
- Reset (rst=0, asynchronous): product register=0, counter=0, latched op=1, busy=0, done=1, result=0. Reset mid-operation aborts immediately; result reads 0 after release.
- Start (rising edge with start=1, from any state, including busy):
  - mcand_abs = |A| and mplier_abs = |B| when sign=1 and the operand's MSB=1; otherwise the raw operand.
  - neg = sign & (A[WIDTH-1] ^ B[WIDTH-1]).
  - Latch op.
  - acc (2*WIDTH+1 bits) = {0, zeros(WIDTH), mplier_abs}; counter = WIDTH; busy=1.
  - Start while busy discards the in-flight operation and restarts with the new operands. No result from the aborted operation is ever presented.
- Iteration (busy=1, start=0, each edge):
  - If acc[0]=1, acc upper half (bits 2*WIDTH:WIDTH) += mcand_abs, with the carry captured in the top bit.
  - Then acc shifts right by 1 (logical); counter decrements.
- Final iteration (counter 1 -> 0):
  - Product register = neg ? two's-complement negation of acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0].
  - busy falls.
- Latency: start sampled at edge N. busy=1 after edges N..N+WIDTH-1; busy=0 and result valid after edge N+WIDTH (32 cycles at default).
- result = latched op ? product[WIDTH-1:0] : product[2*WIDTH-1:WIDTH]. Combinational from registered state only; it does not follow the live op or operand inputs.
- While busy, result shows the previous completed product. Consumers qualify with done.
- Operand inputs and op are don't-care except on the start edge.
- Arithmetic: unsigned magnitude product of two WIDTH-bit values fits in 2*WIDTH bits. The signed -2^(WIDTH-1) * -2^(WIDTH-1) case is exact because magnitudes are treated as unsigned. Zero operands give a zero product with no negative-zero artefact.
- No overflow or exception flags.
- Counter never wraps: iterations occur only when counter>0; when counter=0 and start=0, state holds.

Test Plan:
- Unsigned small, sign=0, op=1, A=7, B=6 -> busy exactly 32 cycles, then done=1, result=0x0000002A; with op=0 -> 0x00000000.
- Signed mixed, sign=1, A=0xFFFFFFFD (-3), B=5 -> op=1 result=0xFFFFFFF1; op=0 result=0xFFFFFFFF.
- Unsigned max, sign=0, A=B=0xFFFFFFFF -> op=0 result=0xFFFFFFFE; op=1 result=0x00000001. Same operands with sign=1 -> high=0x00000000, low=0x00000001.
- Signed extreme, sign=1, A=B=0x80000000 -> op=0 result=0x40000000; op=1 result=0x00000000. Also A=0x80000000, B=1 -> high=0xFFFFFFFF, low=0x80000000.
- Restart and op latching:
  - Start 9*9, then at cycle 10 start 3*4 -> done exactly 32 cycles after the second start, result=0x0000000C, 81 never presented.
  - Toggling op/operand inputs while busy does not change the final result.
- Reset mid-op: assert rst=0 at cycle 15 of a multiply -> busy=0, done=1, result=0 immediately (asynchronous). A fresh 2*3 after release yields 6 in 32 cycles.
